// File: rtl/uart_arbiter_pkg.sv
// +----------------------------------------------------------------------+
// | uart_arbiter_pkg                                                     |
// | Shared types and helpers for the UART buffer port arbiter.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package uart_arbiter_pkg;

  localparam int NREQ_MAX = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } chan_state_t;

  // Index width for the round-robin pointer; never narrower than one bit.
  function automatic int rr_idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_arbiter_channel.sv
// +----------------------------------------------------------------------+
// | uart_arbiter_channel                                                 |
// | One direction of the arbiter: pending bits, data latches, RR FSM.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_arbiter_channel
  import uart_arbiter_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter bit HAS_WDATA = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      i_req,
  input  logic [NREQ*32-1:0]   i_req_data,
  output logic [NREQ-1:0]      o_done,
  output logic [31:0]          o_rsp_data,
  output logic [NREQ-1:0]      o_overlap,
  output logic                 o_buf_en,
  output logic [31:0]          o_buf_data,
  input  logic                 i_buf_done,
  input  logic [31:0]          i_buf_data
);

  localparam int            IW         = rr_idx_width(NREQ);
  localparam logic [IW-1:0] c_LAST_RST = IW'(NREQ - 1);

  chan_state_t     r_state;
  chan_state_t     w_state_nxt;
  logic [NREQ-1:0] r_pending;
  logic [NREQ-1:0] w_clr;
  logic [IW-1:0]   r_grant;
  logic [IW-1:0]   r_last;
  logic [IW-1:0]   w_pick;
  logic [IW-1:0]   w_idx;
  logic            w_any;
  logic            w_complete;
  logic [31:0]     w_grant_data;
  logic            r_buf_en;
  logic [31:0]     r_buf_data;
  logic [NREQ-1:0] r_done;
  logic [31:0]     r_rsp_data;

  // Scan from the highest offset down so the nearest requester after r_last wins.
  always_comb begin
    w_pick = r_last;
    w_idx  = r_last;
    w_any  = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = IW'((int'(r_last) + k) % NREQ);
      if (r_pending[w_idx]) begin
        w_pick = w_idx;
        w_any  = 1'b1;
      end
    end
  end

  assign w_complete = (r_state == WAIT) && i_buf_done;
  assign w_clr      = w_complete ? (NREQ'(1) << r_grant) : '0;
  assign o_overlap  = i_req & r_pending;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_nxt = ISSUE;
      ISSUE:   w_state_nxt = WAIT;
      WAIT:    if (i_buf_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending  <= '0;
      r_grant    <= '0;
      r_last     <= c_LAST_RST;
      r_buf_en   <= 1'b0;
      r_buf_data <= '0;
      r_done     <= '0;
      r_rsp_data <= '0;
    end else begin
      // A request on an already-pending slot is dropped, including the clearing edge.
      r_pending <= (r_pending & ~w_clr) | (i_req & ~r_pending);
      r_buf_en  <= (r_state == ISSUE);
      r_done    <= w_clr;
      if (r_state == IDLE && w_any) r_grant <= w_pick;
      if (r_state == ISSUE) r_buf_data <= w_grant_data;
      if (w_complete) begin
        r_rsp_data <= i_buf_data;
        r_last     <= r_grant;
      end
    end
  end

  if (HAS_WDATA) begin : g_wdata
    logic [31:0] r_wdata [NREQ];

    always_ff @(posedge clk) begin
      for (int i = 0; i < NREQ; i++) begin
        if (rst) r_wdata[i] <= '0;
        else if (i_req[i] && !r_pending[i]) r_wdata[i] <= i_req_data[i*32 +: 32];
      end
    end

    assign w_grant_data = r_wdata[r_grant];
  end else begin : g_nowdata
    assign w_grant_data = '0;
  end

  assign o_buf_en   = r_buf_en;
  assign o_buf_data = r_buf_data;
  assign o_done     = r_done;
  assign o_rsp_data = r_rsp_data;

endmodule

`default_nettype wire

// File: rtl/uart_arbiter.sv
// +----------------------------------------------------------------------+
// | uart_arbiter                                                         |
// | Round-robin sharing of the UART buffer port between NREQ requesters. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_arbiter
  import uart_arbiter_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_renable,
  output logic [NREQ-1:0]      req_rdone,
  output logic [31:0]          req_rdata,
  input  logic [NREQ-1:0]      req_wenable,
  input  logic [NREQ*32-1:0]   req_wdata,
  output logic [NREQ-1:0]      req_wdone,
  output logic                 buf_renable,
  input  logic                 buf_rdone,
  input  logic [31:0]          buf_rdata,
  output logic                 buf_wenable,
  output logic [31:0]          buf_wdata,
  input  logic                 buf_wdone,
  output logic [NREQ-1:0]      err_overlap
);

  logic [NREQ-1:0] w_rd_overlap;
  logic [NREQ-1:0] w_wr_overlap;
  logic [31:0]     w_rd_buf_data_nc;
  logic [31:0]     w_wr_rsp_data_nc;
  logic [NREQ-1:0] r_err_overlap;

  uart_arbiter_channel #(
    .NREQ      (NREQ),
    .HAS_WDATA (1'b0)
  ) u_rd_chan (
    .clk        (clk),
    .rst        (rst),
    .i_req      (req_renable),
    .i_req_data ('0),
    .o_done     (req_rdone),
    .o_rsp_data (req_rdata),
    .o_overlap  (w_rd_overlap),
    .o_buf_en   (buf_renable),
    .o_buf_data (w_rd_buf_data_nc),
    .i_buf_done (buf_rdone),
    .i_buf_data (buf_rdata)
  );

  uart_arbiter_channel #(
    .NREQ      (NREQ),
    .HAS_WDATA (1'b1)
  ) u_wr_chan (
    .clk        (clk),
    .rst        (rst),
    .i_req      (req_wenable),
    .i_req_data (req_wdata),
    .o_done     (req_wdone),
    .o_rsp_data (w_wr_rsp_data_nc),
    .o_overlap  (w_wr_overlap),
    .o_buf_en   (buf_wenable),
    .o_buf_data (buf_wdata),
    .i_buf_done (buf_wdone),
    .i_buf_data ('0)
  );

  always_ff @(posedge clk) begin
    if (rst) r_err_overlap <= '0;
    else     r_err_overlap <= r_err_overlap | w_rd_overlap | w_wr_overlap;
  end

  assign err_overlap = r_err_overlap;

endmodule

`default_nettype wire
